// File: rtl/k580vt57_dma.sv
// K580VT57 (8257-style) four-channel DMA controller.
// CPU register file, priority resolver and transfer FSM.
module k580vt57_dma (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_dma,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        omemr_n,
  output logic        omemw_n,
  output logic        oior_n,
  output logic        oiow_n,
  output logic        tc
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S0   = 3'd1;
  localparam logic [2:0] S1   = 3'd2;
  localparam logic [2:0] S2   = 3'd3;
  localparam logic [2:0] S3   = 3'd4;
  localparam logic [2:0] S4   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] addr_q [4];
  logic [15:0] addr_d [4];
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [7:0]  mode_q, mode_d;
  logic [3:0]  stat_q, stat_d;
  logic        upd_q, upd_d;
  logic        ff_q, ff_d;
  logic        iwe_q, ird_q;
  logic [7:0]  odata_q, odata_d;

  logic        wr_ev, rd_ev, rd_end;
  logic [2:0]  win;
  logic [15:0] cur_cnt;
  logic        is_rd, is_wr, in_s2, in_s3, busy;

  // Returns {valid, channel}; rotating mode starts after the last one served.
  function automatic logic [2:0] pick(
    input logic [3:0] req,
    input logic [1:0] last,
    input logic       rot
  );
    logic [1:0] s;
    logic [1:0] idx;
    pick = 3'b000;
    s = rot ? last + 2'd1 : 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = s + i[1:0];
      if (req[idx]) pick = {1'b1, idx};
    end
  endfunction

  assign wr_ev  = iwe_q & ~iwe_n;
  assign rd_ev  = ird_q & ~ird_n;
  assign rd_end = ~ird_q & ird_n;

  assign cur_cnt = cnt_q[ch_q];
  assign is_rd   = cur_cnt[15:14] == 2'b10;
  assign is_wr   = cur_cnt[15:14] == 2'b01;
  assign in_s2   = state_q == S2;
  assign in_s3   = state_q == S3;
  assign busy    = (state_q == S1) | in_s2 | in_s3 | (state_q == S4);

  assign hrq     = state_q != IDLE;
  assign dack    = (in_s2 | in_s3) ? (4'b0001 << ch_q) : 4'b0000;
  assign oaddr   = busy ? addr_q[ch_q] : 16'h0000;
  assign tc      = in_s3 & (cur_cnt[13:0] == 14'd0);
  assign omemr_n = ~(is_rd & (in_s2 | in_s3));
  assign oiow_n  = ~(is_rd & in_s3);
  assign oior_n  = ~(is_wr & (in_s2 | in_s3));
  assign omemw_n = ~(is_wr & (in_s3 | (mode_q[5] & in_s2)));
  assign odata   = odata_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    stat_d  = stat_q;
    upd_d   = upd_q;
    ff_d    = ff_q;
    odata_d = odata_q;
    win     = 3'b000;

    if (wr_ev) begin
      if (iaddr[3]) begin
        mode_d = idata;
        ff_d   = 1'b0;
      end else begin
        ff_d = ~ff_q;
        for (int j = 0; j < 4; j++) begin
          if ((j[1:0] == iaddr[2:1]) ||
              (mode_q[7] && iaddr[2:1] == 2'd2 && j == 3)) begin
            if (iaddr[0]) begin
              if (ff_q) cnt_d[j][15:8] = idata;
              else      cnt_d[j][7:0]  = idata;
            end else begin
              if (ff_q) addr_d[j][15:8] = idata;
              else      addr_d[j][7:0]  = idata;
            end
          end
        end
      end
    end

    if (rd_ev) begin
      if (iaddr[3]) begin
        odata_d = {3'b000, upd_q, stat_q};
      end else begin
        ff_d = ~ff_q;
        if (iaddr[0])
          odata_d = ff_q ? cnt_q[iaddr[2:1]][15:8]
                         : cnt_q[iaddr[2:1]][7:0];
        else
          odata_d = ff_q ? addr_q[iaddr[2:1]][15:8]
                         : addr_q[iaddr[2:1]][7:0];
      end
    end

    if (rd_end && iaddr[3]) stat_d = 4'b0000;

    if (ce_dma) begin
      case (state_q)
        IDLE: if (|(drq & mode_q[3:0])) state_d = S0;
        S0: begin
          win = pick(drq & mode_q[3:0], last_q, mode_q[4]);
          if (hlda) begin
            if (win[2]) begin
              state_d = S1;
              ch_d    = win[1:0];
            end else begin
              state_d = IDLE;
            end
          end
        end
        S1: state_d = S2;
        S2: state_d = S3;
        S3: state_d = S4;
        S4: begin
          // Transfer bookkeeping overrides a same-cycle CPU write.
          addr_d[ch_q] = addr_q[ch_q] + 16'd1;
          cnt_d[ch_q]  = {cur_cnt[15:14], cur_cnt[13:0] - 14'd1};
          if (cur_cnt[13:0] == 14'd0) begin
            stat_d[ch_q] = 1'b1;
            if (mode_q[6]) mode_d[ch_q] = 1'b0;
            if (mode_q[7] && ch_q == 2'd2) begin
              addr_d[2] = addr_q[3];
              cnt_d[2]  = cnt_q[3];
              upd_d     = 1'b1;
            end
          end else if (ch_q == 2'd2) begin
            upd_d = 1'b0;
          end
          last_d = ch_q;
          win = pick(drq & mode_d[3:0], ch_q, mode_q[4]);
          if (hlda && win[2]) begin
            state_d = S1;
            ch_d    = win[1:0];
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      last_q  <= 2'd3;
      mode_q  <= 8'h00;
      stat_q  <= 4'h0;
      upd_q   <= 1'b0;
      ff_q    <= 1'b0;
      iwe_q   <= 1'b1;
      ird_q   <= 1'b1;
      odata_q <= 8'h00;
      for (int j = 0; j < 4; j++) begin
        addr_q[j] <= 16'h0000;
        cnt_q[j]  <= 16'h0000;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      stat_q  <= stat_d;
      upd_q   <= upd_d;
      ff_q    <= ff_d;
      iwe_q   <= iwe_n;
      ird_q   <= ird_n;
      odata_q <= odata_d;
      for (int j = 0; j < 4; j++) begin
        addr_q[j] <= addr_d[j];
        cnt_q[j]  <= cnt_d[j];
      end
    end
  end

endmodule

// File: doc/k580vt57_dma.md
K580VT57_DMA -- requirements
Module: k580vt57_dma

Interface
REQ-001 Parameter: none; channel count is fixed at 4.
REQ-002 clk_sys  in  1  system clock; clocking is single-clock, all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ce_dma  in  1  clock enable; DMA state machine advances only when ce_dma=1.
REQ-005 iaddr  in  4  CPU register select.
REQ-006 idata / odata  in / out  8  CPU write data / CPU read data.
REQ-007 iwe_n / ird_n  in  1  CPU write / read strobes, active low; act on falling edge.
REQ-008 drq  in  4  per-channel request, active high, level.
REQ-009 dack  out  4  per-channel acknowledge, active high, one-hot or zero.
REQ-010 hrq / hlda  out / in  1  bus request to CPU / bus grant.
REQ-011 oaddr  out  16  memory address during transfer.
REQ-012 omemr_n, omemw_n, oior_n, oiow_n  out  1 each  transfer strobes, active low.
REQ-013 tc  out  1  terminal count, high during last transfer of a block.

Function
REQ-014 Registers: iaddr 0-7 = channel (iaddr[2:1]) address (iaddr[0]=0) or count (iaddr[0]=1); iaddr[3]=1 = mode (write) / status (read).
REQ-015 16-bit registers load through a shared byte flip-flop: low byte first, then high; FF toggles on every 0-7 access, cleared by mode write and reset.
REQ-016 Count register: bits 13:0 = count (transfers = count+1), bits 15:14 = type: 00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 illegal, treated as verify.
REQ-017 Mode register: bits 3:0 channel enable, bit4 rotating priority, bit5 extended write, bit6 TC stop, bit7 autoload.
REQ-018 Status read: bits 3:0 TC flags, bit4 update flag, bits 7:5 = 0; a status read clears bits 3:0 on ird_n rising edge.
REQ-019 With autoload=1, CPU writes to channel 2 registers also write channel 3 registers.
REQ-020 Priority: fixed (ch0 highest); rotating: most recently serviced channel becomes lowest.
REQ-021 FSM states: IDLE, S0 (hrq=1, wait hlda), S1 (latch winner, drive oaddr), S2 (read strobe), S3 (write strobe), S4 (update); one state per ce_dma.
REQ-022 IDLE->S0 when any enabled channel has drq=1; S0->S1 on hlda=1; S1->S2->S3->S4 unconditional.
REQ-023 dack of the serviced channel is high from S2 through S3 and low in S1 and S4.
REQ-024 Read type: omemr_n low in S2-S3, oiow_n low in S3. Write type: oior_n low in S2-S3, omemw_n low in S3, or S2-S3 if extended write. Verify type: no strobes, dack still pulses.
REQ-025 S4: address+1 (wraps FFFF->0000); count-1 in bits 13:0; tc high in S3 when count was 0.
REQ-026 On TC: set status flag of the channel. If TC stop is set, clear that channel's enable bit. If autoload is set and the channel is 2, reload ch2 address/count/type from ch3 and set the update flag.
REQ-027 The update flag clears on the first later ch2 transfer that does not reach TC.
REQ-028 S4 exit: another enabled drq with hlda=1 -> S1 (burst, hrq stays high); else -> IDLE with hrq=0.
REQ-029 hlda dropping in S1-S3 completes the cycle; S4 then returns to IDLE.
REQ-030 A CPU register write during S1-S4 takes effect; S4 updates of the same register in the same clk_sys cycle take priority.
REQ-031 drq deassert in S2/S3 does not abort the current byte.

Reset
REQ-032 reset_n=0 sets mode, status, byte FF and all channel registers to 0, FSM to IDLE, hrq=0, tc=0, dack=0, all strobes=1, oaddr=0, odata=0.
REQ-033 Reset mid-transfer aborts immediately; no register update occurs.

Verification
REQ-034 Program ch2 addr=0x1000, count=0x8003 (read, 4 bytes), mode=0x04, drq[2]=1, hlda=1 -> 4 cycles at oaddr 1000-1003, omemr_n/oiow_n pulses, tc high on the 4th, status=0x04, enable[2] still set.
REQ-035 Same with mode=0x84 and ch3 preloaded with 0x2000/0x8001 via ch2 writes -> after 4 bytes ch2 reloads to 0x2000, status bit4=1, next transfer at 0x2000.
REQ-036 drq=4'b0011, fixed priority -> ch0 serviced until disabled; rotating -> service alternates ch0, ch1, ch0.
REQ-037 Mode=0x41, ch0 count=0x4000 -> single transfer, tc=1, mode bit0 cleared, hrq falls.
REQ-038 Assert reset_n=0 in S2 -> strobes go high and dack=0 with no clock edge; count unchanged after re-program check.
